// File: rtl/fmul_pipe.sv
// IEEE-754 binary multiplier with a 3-stage valid/ready pipeline:
// S1 unpack + special detect + significand product, S2 normalize + sticky, S3 round + pack + flags.
module fmul_pipe #(
  parameter int unsigned EXP_W  = 8,
  parameter int unsigned FRAC_W = 23
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  in_valid,
  output logic                  in_ready,
  input  logic [EXP_W+FRAC_W:0] a,
  input  logic [EXP_W+FRAC_W:0] b,
  input  logic [1:0]            rm,
  output logic                  out_valid,
  input  logic                  out_ready,
  output logic [EXP_W+FRAC_W:0] z,
  output logic [3:0]            flags
);
  localparam int unsigned W    = 1 + EXP_W + FRAC_W;
  localparam int unsigned MW   = FRAC_W + 1;
  localparam int unsigned PW   = 2 * MW;
  localparam int unsigned EW2  = EXP_W + 2;
  localparam int unsigned LZ_W = $clog2(PW + 1);
  localparam int unsigned BIAS = (1 << (EXP_W - 1)) - 1;
  localparam int unsigned EMAX = (1 << EXP_W) - 1;

  localparam logic [1:0] RM_RNE = 2'b00;
  localparam logic [1:0] RM_RTZ = 2'b01;
  localparam logic [1:0] RM_RDN = 2'b10;
  localparam logic [1:0] RM_RUP = 2'b11;

  // Leading-zero count of the raw product; PW when the product is zero.
  function automatic logic [LZ_W-1:0] clz(input logic [PW-1:0] v);
    logic [LZ_W-1:0] n;
    n = LZ_W'(PW);
    for (int i = 0; i < PW; i++)
      if (v[i]) n = LZ_W'(PW - 1 - i);
    return n;
  endfunction

  logic adv;

  // Stage registers; spc = {nan, invalid, inf, zero}
  logic                  v1_q, v1_d, v2_q, v2_d, out_valid_q, out_valid_d;
  logic                  s1_sign_q, s1_sign_d, s2_sign_q, s2_sign_d;
  logic [1:0]            s1_rm_q, s1_rm_d, s2_rm_q, s2_rm_d;
  logic [3:0]            s1_spc_q, s1_spc_d, s2_spc_q, s2_spc_d;
  logic signed [EW2-1:0] s1_exp_q, s1_exp_d, s2_exp_q, s2_exp_d;
  logic [PW-1:0]         s1_prod_q, s1_prod_d;
  logic [MW-1:0]         s2_mant_q, s2_mant_d;
  logic                  s2_grd_q, s2_grd_d, s2_stk_q, s2_stk_d, s2_tiny_q, s2_tiny_d;
  logic [W-1:0]          z_q, z_d;
  logic [3:0]            flags_q, flags_d;

  assign adv       = ~out_valid_q | out_ready;
  assign in_ready  = adv;
  assign out_valid = out_valid_q;
  assign z         = z_q;
  assign flags     = flags_q;

  // Operand unpack
  logic [EXP_W-1:0]      xa, xb;
  logic [FRAC_W-1:0]     fa, fb;
  logic                  a_nan, b_nan, a_inf, b_inf, a_zero, b_zero;
  logic [MW-1:0]         ma, mb;
  logic signed [EW2-1:0] ea, eb;

  assign xa     = a[FRAC_W +: EXP_W];
  assign xb     = b[FRAC_W +: EXP_W];
  assign fa     = a[FRAC_W-1:0];
  assign fb     = b[FRAC_W-1:0];
  assign a_nan  = (&xa) & (|fa);
  assign b_nan  = (&xb) & (|fb);
  assign a_inf  = (&xa) & ~(|fa);
  assign b_inf  = (&xb) & ~(|fb);
  assign a_zero = ~(|xa) & ~(|fa);
  assign b_zero = ~(|xb) & ~(|fb);
  assign ma     = {|xa, fa};
  assign mb     = {|xb, fb};
  assign ea     = (|xa) ? EW2'(xa) : EW2'(1'b1);
  assign eb     = (|xb) ? EW2'(xb) : EW2'(1'b1);

  // S1: special-case classification, biased exponent sum, full significand product
  always_comb begin
    v1_d      = v1_q;
    s1_sign_d = s1_sign_q;
    s1_rm_d   = s1_rm_q;
    s1_spc_d  = s1_spc_q;
    s1_exp_d  = s1_exp_q;
    s1_prod_d = s1_prod_q;
    if (adv) begin
      v1_d        = in_valid;
      s1_sign_d   = a[W-1] ^ b[W-1];
      s1_rm_d     = rm;
      s1_spc_d[3] = a_nan | b_nan | (a_inf & b_zero) | (a_zero & b_inf);
      s1_spc_d[2] = (a_nan & ~fa[FRAC_W-1]) | (b_nan & ~fb[FRAC_W-1]) |
                    (a_inf & b_zero) | (a_zero & b_inf);
      s1_spc_d[1] = a_inf | b_inf;
      s1_spc_d[0] = a_zero | b_zero;
      s1_exp_d    = ea + eb - EW2'(BIAS);
      s1_prod_d   = PW'(ma) * PW'(mb);
    end
  end

  // S2: normalize to MSB, then shift tiny results into denormal position
  logic [LZ_W-1:0]       lz, sh;
  logic [PW-1:0]         pn, pd;
  logic [2*PW-1:0]       wide;
  logic signed [EW2-1:0] exp_n, dsh;
  logic                  tiny;

  always_comb begin
    lz    = clz(s1_prod_q);
    pn    = s1_prod_q << lz;
    exp_n = s1_exp_q + EW2'(1) - EW2'(lz);
    tiny  = exp_n[EW2-1] | (exp_n == '0);
    dsh   = EW2'(1) - exp_n;
    sh    = '0;
    if (tiny) sh = (dsh > EW2'(PW)) ? LZ_W'(PW) : LZ_W'(dsh);
    wide  = {pn, PW'(0)} >> sh;
    pd    = wide[2*PW-1 -: PW];

    v2_d      = v2_q;
    s2_sign_d = s2_sign_q;
    s2_rm_d   = s2_rm_q;
    s2_spc_d  = s2_spc_q;
    s2_exp_d  = s2_exp_q;
    s2_mant_d = s2_mant_q;
    s2_grd_d  = s2_grd_q;
    s2_stk_d  = s2_stk_q;
    s2_tiny_d = s2_tiny_q;
    if (adv) begin
      v2_d      = v1_q;
      s2_sign_d = s1_sign_q;
      s2_rm_d   = s1_rm_q;
      s2_spc_d  = s1_spc_q;
      s2_exp_d  = tiny ? '0 : exp_n;
      s2_mant_d = pd[PW-1 -: MW];
      s2_grd_d  = pd[PW-1-MW];
      s2_stk_d  = (|pd[PW-2-MW:0]) | (|wide[PW-1:0]);
      s2_tiny_d = tiny;
    end
  end

  // S3: round, detect overflow, pack and select special results
  logic                  inexact, inc, to_inf, ovf;
  logic [MW:0]           mr;
  logic signed [EW2-1:0] exp_f;

  always_comb begin
    inexact = s2_grd_q | s2_stk_q;
    inc     = 1'b0;
    case (s2_rm_q)
      RM_RNE: inc = s2_grd_q & (s2_stk_q | s2_mant_q[0]);
      RM_RTZ: inc = 1'b0;
      RM_RDN: inc = s2_sign_q & inexact;
      RM_RUP: inc = ~s2_sign_q & inexact;
      default: inc = 1'b0;
    endcase
    // A carry out of the significand, or a denormal rounding into the hidden bit, bumps the exponent.
    mr     = {1'b0, s2_mant_q} + (MW+1)'(inc);
    exp_f  = s2_exp_q + EW2'(mr[MW] | ((s2_exp_q == '0) & mr[MW-1]));
    ovf    = exp_f >= EW2'(EMAX);
    to_inf = (s2_rm_q == RM_RNE) | ((s2_rm_q == RM_RUP) & ~s2_sign_q) |
             ((s2_rm_q == RM_RDN) & s2_sign_q);

    out_valid_d = out_valid_q;
    z_d         = z_q;
    flags_d     = flags_q;
    if (adv) begin
      out_valid_d = v2_q;
      if (s2_spc_q[3]) begin
        z_d     = {1'b0, {EXP_W{1'b1}}, 1'b1, (FRAC_W-1)'(0)};
        flags_d = {s2_spc_q[2], 3'b000};
      end else if (s2_spc_q[1]) begin
        z_d     = {s2_sign_q, {EXP_W{1'b1}}, FRAC_W'(0)};
        flags_d = 4'b0000;
      end else if (s2_spc_q[0]) begin
        z_d     = {s2_sign_q, (W-1)'(0)};
        flags_d = 4'b0000;
      end else if (ovf) begin
        z_d     = to_inf ? {s2_sign_q, {EXP_W{1'b1}}, FRAC_W'(0)}
                         : {s2_sign_q, {(EXP_W-1){1'b1}}, 1'b0, {FRAC_W{1'b1}}};
        flags_d = 4'b0101;
      end else begin
        z_d     = {s2_sign_q, exp_f[EXP_W-1:0], mr[FRAC_W-1:0]};
        flags_d = {2'b00, s2_tiny_q & inexact, inexact};
      end
    end
  end

  // Control and output state
  always_ff @(posedge clk) begin
    if (rst) begin
      v1_q        <= 1'b0;
      v2_q        <= 1'b0;
      out_valid_q <= 1'b0;
      z_q         <= '0;
      flags_q     <= '0;
    end else begin
      v1_q        <= v1_d;
      v2_q        <= v2_d;
      out_valid_q <= out_valid_d;
      z_q         <= z_d;
      flags_q     <= flags_d;
    end
  end

  // Datapath registers carry no reset; their contents are qualified by the valid bits.
  always_ff @(posedge clk) begin
    s1_sign_q <= s1_sign_d;
    s1_rm_q   <= s1_rm_d;
    s1_spc_q  <= s1_spc_d;
    s1_exp_q  <= s1_exp_d;
    s1_prod_q <= s1_prod_d;
    s2_sign_q <= s2_sign_d;
    s2_rm_q   <= s2_rm_d;
    s2_spc_q  <= s2_spc_d;
    s2_exp_q  <= s2_exp_d;
    s2_mant_q <= s2_mant_d;
    s2_grd_q  <= s2_grd_d;
    s2_stk_q  <= s2_stk_d;
    s2_tiny_q <= s2_tiny_d;
  end
endmodule

// File: tb/tb_fmul_pipe.sv
// Directed single-precision bench for fmul_pipe: vector table, stalled stream, reset with tokens in flight.
module tb_fmul_pipe;
  logic        clk = 1'b0;
  logic        rst, in_valid, in_ready, out_valid, out_ready;
  logic [31:0] a, b, z;
  logic [1:0]  rm;
  logic [3:0]  flags;

  fmul_pipe dut (
    .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready),
    .a(a), .b(b), .rm(rm), .out_valid(out_valid), .out_ready(out_ready),
    .z(z), .flags(flags)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [31:0] a;
    logic [31:0] b;
    logic [1:0]  rm;
    logic [31:0] z;
    logic [3:0]  fl;
  } vec_t;

  vec_t        vq[$];
  int          errs = 0;
  int          checks = 0;
  int          sent, recv, cyc;
  bit          held;
  logic        adv_m, exp_rdy;
  logic [2:0]  mv;
  logic [31:0] hz;
  logic [3:0]  hf;

  task automatic add(input logic [31:0] ia, input logic [31:0] ib, input logic [1:0] irm,
                     input logic [31:0] iz, input logic [3:0] ifl);
    vec_t v;
    v.a = ia; v.b = ib; v.rm = irm; v.z = iz; v.fl = ifl;
    vq.push_back(v);
  endtask

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errs++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  // One operand pair with out_ready high; latency counted in edges from the accept edge.
  task automatic run_vec(input int i);
    int k;
    bit got;
    @(negedge clk);
    a = vq[i].a; b = vq[i].b; rm = vq[i].rm; in_valid = 1'b1; out_ready = 1'b1;
    @(negedge clk);
    in_valid = 1'b0;
    k = 1;
    got = 1'b0;
    while (!got && k < 10) begin
      @(negedge clk);
      k++;
      got = out_valid;
    end
    chk($sformatf("vec%0d latency", i), k, 3);
    chk($sformatf("vec%0d z", i), z, vq[i].z);
    chk($sformatf("vec%0d flags", i), 32'(flags), 32'(vq[i].fl));
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  initial begin
    add(32'h3FC00000, 32'h40000000, 2'd0, 32'h40400000, 4'b0000);
    add(32'h7F7FFFFF, 32'h40000000, 2'd0, 32'h7F800000, 4'b0101);
    add(32'h7F7FFFFF, 32'h40000000, 2'd1, 32'h7F7FFFFF, 4'b0101);
    add(32'h7F7FFFFF, 32'h40000000, 2'd2, 32'h7F7FFFFF, 4'b0101);
    add(32'h7F7FFFFF, 32'h40000000, 2'd3, 32'h7F800000, 4'b0101);
    add(32'hFF7FFFFF, 32'h40000000, 2'd2, 32'hFF800000, 4'b0101);
    add(32'hFF7FFFFF, 32'h40000000, 2'd3, 32'hFF7FFFFF, 4'b0101);
    add(32'h7F800000, 32'h00000000, 2'd0, 32'h7FC00000, 4'b1000);
    add(32'hFF800000, 32'h40000000, 2'd0, 32'hFF800000, 4'b0000);
    add(32'h00800000, 32'h3F000000, 2'd0, 32'h00400000, 4'b0000);
    add(32'h00800001, 32'h3F000000, 2'd0, 32'h00400000, 4'b0011);
    add(32'h00800001, 32'h3F000000, 2'd3, 32'h00400001, 4'b0011);
    add(32'h80000000, 32'h3F800000, 2'd0, 32'h80000000, 4'b0000);
    add(32'h7FC00000, 32'h3F800000, 2'd0, 32'h7FC00000, 4'b0000);
    add(32'h7F800001, 32'h3F800000, 2'd0, 32'h7FC00000, 4'b1000);
    add(32'h3F800001, 32'h3F800001, 2'd0, 32'h3F800002, 4'b0001);
    add(32'h3F800001, 32'h3F800001, 2'd3, 32'h3F800003, 4'b0001);
    add(32'h007FFFFF, 32'h3F800001, 2'd0, 32'h00800000, 4'b0011);
    add(32'h007FFFFF, 32'h3F800001, 2'd1, 32'h007FFFFF, 4'b0011);
    add(32'h00000001, 32'h00000001, 2'd0, 32'h00000000, 4'b0011);
    add(32'h00000001, 32'h00000001, 2'd3, 32'h00000001, 4'b0011);
    add(32'h7F800000, 32'hFF800000, 2'd0, 32'hFF800000, 4'b0000);
    add(32'h3F800001, 32'h3FC00000, 2'd0, 32'h3FC00002, 4'b0001);
    add(32'h3F800001, 32'h3FC00000, 2'd1, 32'h3FC00001, 4'b0001);
    add(32'h3F800000, 32'hC0000000, 2'd0, 32'hC0000000, 4'b0000);
    add(32'h00000000, 32'h7F7FFFFF, 2'd0, 32'h00000000, 4'b0000);
    add(32'hBF800000, 32'hFF800000, 2'd0, 32'h7F800000, 4'b0000);
    add(32'hBF800001, 32'h3F800001, 2'd2, 32'hBF800003, 4'b0001);
    add(32'hBF800001, 32'h3F800001, 2'd3, 32'hBF800002, 4'b0001);

    rst = 1'b1; in_valid = 1'b0; out_ready = 1'b1; a = '0; b = '0; rm = 2'd0;
    repeat (3) @(negedge clk);
    rst = 1'b0; out_ready = 1'b0;
    #1;
    chk("reset out_valid", 32'(out_valid), 32'd0);
    chk("reset z", z, 32'd0);
    chk("reset flags", 32'(flags), 32'd0);
    chk("reset in_ready", 32'(in_ready), 32'd1);

    foreach (vq[i]) run_vec(i);

    // Back-to-back stream with random backpressure against a valid-bit model.
    sent = 0; recv = 0; cyc = 0; held = 1'b0; mv = 3'b000;
    while (recv < 8 && cyc < 300) begin
      @(negedge clk);
      cyc++;
      out_ready = ($urandom_range(0, 2) != 0);
      if (sent < 8) begin
        a = vq[sent].a; b = vq[sent].b; rm = vq[sent].rm; in_valid = 1'b1;
      end else begin
        in_valid = 1'b0;
      end
      #1;
      exp_rdy = ~mv[2] | out_ready;
      chk("stream out_valid", 32'(out_valid), 32'(mv[2]));
      chk("stream in_ready", 32'(in_ready), 32'(exp_rdy));
      if (held) begin
        chk("stall z", z, hz);
        chk("stall flags", 32'(flags), 32'(hf));
      end
      held = out_valid & ~out_ready;
      hz = z;
      hf = flags;
      if (out_valid && out_ready) begin
        if (recv < 8) begin
          chk($sformatf("stream%0d z", recv), z, vq[recv].z);
          chk($sformatf("stream%0d flags", recv), 32'(flags), 32'(vq[recv].fl));
        end
        recv++;
      end
      adv_m = ~mv[2] | out_ready;
      if (adv_m) begin
        mv = {mv[1:0], in_valid};
        if (in_valid) sent++;
      end
    end
    chk("stream result count", recv, 8);
    in_valid = 1'b0; out_ready = 1'b1;
    repeat (4) begin
      @(negedge clk);
      chk("post-stream out_valid", 32'(out_valid), 32'd0);
    end

    // Three tokens in flight, then reset with an accept pending.
    @(negedge clk);
    out_ready = 1'b0; in_valid = 1'b1;
    a = vq[0].a; b = vq[0].b; rm = vq[0].rm;
    repeat (3) @(negedge clk);
    chk("in-flight out_valid", 32'(out_valid), 32'd1);
    rst = 1'b1; out_ready = 1'b1;
    @(negedge clk);
    rst = 1'b0; in_valid = 1'b0;
    #1;
    chk("rst out_valid", 32'(out_valid), 32'd0);
    chk("rst z", z, 32'd0);
    chk("rst flags", 32'(flags), 32'd0);
    chk("rst in_ready", 32'(in_ready), 32'd1);
    repeat (6) begin
      @(negedge clk);
      chk("post-rst out_valid", 32'(out_valid), 32'd0);
    end
    run_vec(0);

    $display("Result: errors=%0d of %0d checks", errs, checks);
    $finish;
  end
endmodule
